foot_packer: RTL and testbench

- Transmit-side counterpart of the foot-sensor byte-stream receiver.
- Snapshots a 32-bit microsecond timestamp and 32 pressure bytes on a start strobe. Emits them as one contiguous 40-byte frame on a byte-wide txd/txdv interface, one byte per clock.
- Used to drive the foot link from the sensor-side FPGA, and as loopback stimulus for the motor-controller receive path.

---
 rtl/foot_packer_pkg.sv | 23 ++
 rtl/foot_packer_snapshot.sv | 34 +++
 rtl/foot_packer.sv | 141 ++++++++++++++
 tb/tb_foot_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/foot_packer_pkg.sv
// Shared foot-link constants and the packer state encoding.
// The receive side imports the same frame geometry from here.
package foot_packer_pkg;

   localparam int unsigned FOOT_HDR_BYTES      = 4;
   localparam int unsigned FOOT_USECS_BYTES    = 4;
   localparam int unsigned FOOT_PRESSURE_BYTES = 32;
   localparam int unsigned FOOT_FRAME_BYTES    =
      FOOT_HDR_BYTES + FOOT_USECS_BYTES + FOOT_PRESSURE_BYTES;

   localparam logic [31:0] FOOT_DEFAULT_HEADER = 32'h0000_00A5;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2
   } foot_state_e;

   function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input logic [1:0] idx);
      return hdr[8*idx +: 8];
   endfunction

endpackage

// File: rtl/foot_packer_snapshot.sv
// Load-enabled snapshot of the timestamp and pressure bytes with a byte-select read port.
// Byte 0..3 hold the timestamp (little-endian), byte 4+i holds pressure byte i.
module foot_packer_snapshot
   import foot_packer_pkg::*;
#(
   parameter int unsigned Bytes = FOOT_USECS_BYTES + FOOT_PRESSURE_BYTES,
   parameter int unsigned SelW  = $clog2(Bytes)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic [8*Bytes-1:0] data_i,
   input  logic [SelW-1:0]    sel_i,
   output logic [7:0]         byte_o
);

   logic [8*Bytes-1:0] snap_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_q <= '0;
      end else if (load_i) begin
         snap_q <= data_i;
      end
   end

   always_comb begin
      byte_o = 8'h00;
      if (32'(sel_i) < Bytes) begin
         byte_o = snap_q[8*32'(sel_i) +: 8];
      end
   end

endmodule

// File: rtl/foot_packer.sv
// Foot-link transmitter: snapshots timestamp and pressures on start and emits one
// contiguous header/usecs/pressure frame, one byte per clock, followed by an idle gap.
module foot_packer
   import foot_packer_pkg::*;
#(
   parameter logic [31:0] HEADER             = FOOT_DEFAULT_HEADER,
   parameter int unsigned NUM_PRESSURE_BYTES = FOOT_PRESSURE_BYTES,
   parameter int unsigned IFG                = 2
) (
   input  logic                            c,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [31:0]                     usecs,
   input  logic [8*NUM_PRESSURE_BYTES-1:0] pressures,
   output logic [7:0]                      txd,
   output logic                            txdv,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned FrameBytes = FOOT_HDR_BYTES + FOOT_USECS_BYTES + NUM_PRESSURE_BYTES;
   localparam int unsigned SnapBytes  = FOOT_USECS_BYTES + NUM_PRESSURE_BYTES;
   localparam int unsigned SelW       = $clog2(SnapBytes);
   localparam int unsigned CntW       = (NUM_PRESSURE_BYTES > 55) ? $clog2(FrameBytes) : 6;
   localparam int unsigned IfgEff     = (IFG < 1) ? 1 : IFG;
   localparam int unsigned GapW       = $clog2(IfgEff + 1);

   localparam logic [CntW-1:0] LastIdx = CntW'(FrameBytes - 1);
   localparam logic [CntW-1:0] HdrEnd  = CntW'(FOOT_HDR_BYTES);
   localparam logic [GapW-1:0] GapLast = GapW'(IfgEff - 1);

   foot_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [7:0]      txd_q, txd_d;
   logic            txdv_q, txdv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            accept;
   logic [CntW-1:0] nxt;
   logic [SelW-1:0] snap_sel;
   logic [7:0]      snap_byte;

   assign nxt      = cnt_q + CntW'(1);
   assign snap_sel = SelW'(nxt - HdrEnd);

   foot_packer_snapshot #(
      .Bytes (SnapBytes),
      .SelW  (SelW)
   ) u_snapshot (
      .clk_i  (c),
      .rst_ni (rst_n),
      .load_i (accept),
      .data_i ({pressures, usecs}),
      .sel_i  (snap_sel),
      .byte_o (snap_byte)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      txd_d   = 8'h00;
      txdv_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      accept  = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            accept = start;
         end
         StSend: begin
            busy_d = 1'b1;
            if (cnt_q == LastIdx) begin
               state_d = StGap;
               gap_d   = '0;
            end else begin
               cnt_d  = nxt;
               txdv_d = 1'b1;
               txd_d  = (nxt < HdrEnd) ? hdr_byte(HEADER, nxt[1:0]) : snap_byte;
               done_d = (nxt == LastIdx);
            end
         end
         StGap: begin
            busy_d = 1'b1;
            // The final gap edge doubles as the idle edge so a held start yields exactly IFG gaps.
            if (gap_q == GapLast) begin
               accept = start;
               if (!start) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase

      if (accept) begin
         state_d = StSend;
         cnt_d   = '0;
         txdv_d  = 1'b1;
         txd_d   = HEADER[7:0];
         busy_d  = 1'b1;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         gap_q   <= '0;
         txd_q   <= 8'h00;
         txdv_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         txd_q   <= txd_d;
         txdv_q  <= txdv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd  = txd_q;
   assign txdv = txdv_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_foot_packer.sv
// Randomized scoreboard bench for foot_packer: the driver predicts each frame as a list of
// timed bytes, a monitor and a loopback receiver compare what the DUT actually sends.
module tb_foot_packer;

   localparam int unsigned NP    = 32;
   localparam int unsigned FRAME = 8 + NP;
   localparam int unsigned IFG   = 2;
   localparam logic [31:0] HDR   = 32'h0000_00A5;

   logic            c = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [31:0]     usecs = '0;
   logic [8*NP-1:0] pressures = '0;
   logic [7:0]      txd;
   logic            txdv;
   logic            busy;
   logic            done;

   foot_packer #(
      .HEADER             (HDR),
      .NUM_PRESSURE_BYTES (NP),
      .IFG                (IFG)
   ) dut (
      .c         (c),
      .rst_n     (rst_n),
      .start     (start),
      .usecs     (usecs),
      .pressures (pressures),
      .txd       (txd),
      .txdv      (txdv),
      .busy      (busy),
      .done      (done)
   );

   always #5 c = ~c;

   int unsigned cyc = 0;
   always @(posedge c) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  data;
      bit          last;
   } exp_t;

   exp_t            exp_q[$];
   logic [31:0]     usecs_q[$];
   logic [8*NP-1:0] press_q[$];
   int unsigned     next_ok = 0;
   int unsigned     acc_e = 0;
   int              n_cmp = 0;
   int              n_fail = 0;

   task automatic check(input bit ok, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic randomize_inputs();
      usecs = $urandom;
      for (int w = 0; w < NP / 4; w++) pressures[32*w +: 32] = $urandom;
   endtask

   // A frame is the header, the timestamp and the pressures as little-endian bytes, one per
   // cycle from the edge after the accepting edge; the link is then busy for IFG more cycles.
   task automatic accept_frame(input int unsigned e);
      logic [7:0] b;
      for (int k = 0; k < int'(FRAME); k++) begin
         if (k < 4)      b = 8'(HDR >> (8 * k));
         else if (k < 8) b = 8'(usecs >> (8 * (k - 4)));
         else            b = 8'(pressures >> (8 * (k - 8)));
         exp_q.push_back('{cyc: e + int'(k), data: b, last: (k == int'(FRAME) - 1)});
      end
      usecs_q.push_back(usecs);
      press_q.push_back(pressures);
      acc_e   = e;
      next_ok = e + FRAME + IFG;
   endtask

   task automatic tick(input bit s, input bit scramble);
      start = s;
      if (s && (cyc + 1) >= next_ok) accept_frame(cyc + 1);
      @(negedge c);
      #1;
      if (scramble) randomize_inputs();
   endtask

   task automatic check_reset_outputs(input string tag);
      check(txdv === 1'b0, {tag, "_txdv"}, 64'(txdv), 64'(0));
      check(busy === 1'b0, {tag, "_busy"}, 64'(busy), 64'(0));
      check(done === 1'b0, {tag, "_done"}, 64'(done), 64'(0));
      check(txd === 8'h00, {tag, "_txd"}, 64'(txd), 64'(0));
   endtask

   // Monitor and loopback receiver.
   int unsigned     rx_cnt = 0;
   logic [31:0]     rx_us = '0;
   logic [8*NP-1:0] rx_pr = '0;

   initial begin
      exp_t            e;
      logic [31:0]     eu;
      logic [8*NP-1:0] ep;
      bit              exp_busy;
      forever begin
         @(negedge c);
         if (!rst_n) begin
            rx_cnt = 0;
         end else begin
            exp_busy = (cyc >= acc_e) && (cyc < next_ok);
            check(busy === exp_busy, "busy", 64'(busy), 64'(exp_busy));
            if (txdv === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_byte", 64'(txd), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  check(cyc == e.cyc, "byte_cycle", 64'(cyc), 64'(e.cyc));
                  check(txd === e.data, "txd", 64'(txd), 64'(e.data));
                  check(done === e.last, "done", 64'(done), 64'(e.last));
               end
               if (rx_cnt >= 4 && rx_cnt < 8) rx_us[8*(rx_cnt-4) +: 8] = txd;
               else if (rx_cnt >= 8 && rx_cnt < FRAME) rx_pr[8*(rx_cnt-8) +: 8] = txd;
               rx_cnt++;
               if (done === 1'b1) begin
                  if (usecs_q.size() == 0) begin
                     check(1'b0, "rx_unexpected_frame", 64'(rx_us), 64'(0));
                  end else begin
                     eu = usecs_q.pop_front();
                     ep = press_q.pop_front();
                     check(rx_cnt == FRAME, "rx_len", 64'(rx_cnt), 64'(FRAME));
                     check(rx_us == eu, "rx_usecs", 64'(rx_us), 64'(eu));
                     check(rx_pr == ep, "rx_pressures", 64'(rx_pr[63:0]), 64'(ep[63:0]));
                  end
               end
            end else begin
               rx_cnt = 0;
               check(txd === 8'h00, "txd_idle", 64'(txd), 64'(0));
               check(done === 1'b0, "done_idle", 64'(done), 64'(0));
               if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                  check(1'b0, "missing_byte", 64'(0), 64'(exp_q[0].cyc));
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge c);
      #1;
      rst_n = 1'b1;
      repeat (5) tick(1'b0, 1'b0);

      // Directed single frame.
      usecs = 32'h1234_5678;
      for (int i = 0; i < int'(NP); i++) pressures[8*i +: 8] = 8'(i + 1);
      tick(1'b1, 1'b0);
      repeat (FRAME + IFG + 3) tick(1'b0, 1'b0);

      // Snapshot isolation with starts at byte 10 and inside the gap.
      randomize_inputs();
      tick(1'b1, 1'b1);
      for (int k = 1; k < int'(FRAME + IFG + 4); k++) tick(k == 10 || k == int'(FRAME) + 1, 1'b1);

      // Random start traffic.
      repeat (600) tick($urandom_range(0, 9) == 0, 1'b1);
      repeat (FRAME + IFG + 2) tick(1'b0, 1'b1);

      // Back-to-back with start held high.
      repeat (3 * (FRAME + IFG) + 2) tick(1'b1, 1'b1);
      repeat (FRAME + IFG + 3) tick(1'b0, 1'b1);

      // Reset at byte 20, then a clean frame.
      tick(1'b1, 1'b1);
      repeat (20) tick(1'b0, 1'b1);
      rst_n = 1'b0;
      exp_q.delete();
      usecs_q.delete();
      press_q.delete();
      acc_e   = 0;
      next_ok = 0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(negedge c);
      #1;
      rst_n = 1'b1;
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      repeat (FRAME + IFG + 3) tick(1'b0, 1'b1);

      check(exp_q.size() == 0, "bytes_left", 64'(exp_q.size()), 64'(0));
      check(usecs_q.size() == 0, "frames_left", 64'(usecs_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
